// File: rtl/mem_stream_ctrl_if.sv
// mem_stream_ctrl_if: command, load/dump stream and RAM master signals of mem_stream_ctrl.
interface mem_stream_ctrl_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 6
);
   logic              load_start, dump_start;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   len;
   logic [WIDTH-1:0]  in_data;
   logic              in_valid, in_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid, out_ready;
   logic [WIDTH-1:0]  mem_data, mem_q;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wr_en;
   logic              busy, done;
   modport master (
      input  load_start, dump_start, base, len, in_data, in_valid, out_ready, mem_q,
      output in_ready, out_data, out_valid, mem_data, mem_address, mem_wr_en, busy, done
   );
   modport slave (
      output load_start, dump_start, base, len, in_data, in_valid, out_ready, mem_q,
      input  in_ready, out_data, out_valid, mem_data, mem_address, mem_wr_en, busy, done
   );
endinterface

// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: loads a stream into a single-port RAM and dumps a RAM range to a stream.
// Define MEM_STREAM_CTRL_SKID_EN for a 2-entry output buffer sustaining 1 word/cycle on dump.
module mem_stream_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 6
) (
   input logic               clock,
   input logic               rst,
   mem_stream_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;
   localparam logic [ADDR_W:0] LEN1 = 1;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q;
   logic [ADDR_W:0]   rem_q, rem_d, orem_q, orem_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [WIDTH-1:0]  b0_q, b0_d;
   logic              start, wr, pop, issue, ovalid;
`ifdef MEM_STREAM_CTRL_SKID_EN
   logic [WIDTH-1:0]  b1_q, b1_d;
   always_ff @(posedge clock or posedge rst) begin
      if (rst) b1_q <= '0;
      else b1_q <= b1_d;
   end
`endif
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         addr_q     <= '0;
         rem_q      <= '0;
         orem_q     <= '0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         b0_q       <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         addr_q     <= bus.mem_address;
         rem_q      <= rem_d;
         orem_q     <= orem_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         b0_q       <= b0_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !start ? IDLE : bus.len == '0 ? DONE : bus.load_start ? LOAD : DUMP;
         LOAD:    state_d = (wr && rem_q == LEN1) ? DONE : LOAD;
         DUMP:    state_d = (pop && orem_q == LEN1) ? DONE : DUMP;
         default: state_d = IDLE;
      endcase
   end
   // The word returning from RAM bypasses the buffer when the buffer is empty.
   always_comb begin
      start  = state_q == IDLE && (bus.load_start || bus.dump_start);
      wr     = state_q == LOAD && bus.in_valid;
      ovalid = state_q == DUMP && (cnt_q != 2'd0 || inflight_q);
      pop    = ovalid && bus.out_ready;
      cnt_d  = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
`ifdef MEM_STREAM_CTRL_SKID_EN
      issue  = state_q == DUMP && rem_q != '0 && cnt_d != 2'd2;
      b0_d   = (pop && cnt_q == 2'd2) ? b1_q : (inflight_q && cnt_d == 2'd1) ? bus.mem_q : b0_q;
      b1_d   = (inflight_q && cnt_d == 2'd2) ? bus.mem_q : b1_q;
`else
      issue  = state_q == DUMP && rem_q != '0 && cnt_q == 2'd0 && !inflight_q;
      b0_d   = (inflight_q && cnt_d == 2'd1) ? bus.mem_q : b0_q;
`endif
      inflight_d      = issue;
      ptr_d           = start ? bus.base : (wr || issue) ? ptr_q + ADDR_W'(1) : ptr_q;
      rem_d           = start ? bus.len : (wr || issue) ? rem_q - LEN1 : rem_q;
      orem_d          = start ? bus.len : pop ? orem_q - LEN1 : orem_q;
      bus.in_ready    = state_q == LOAD;
      bus.mem_wr_en   = wr;
      bus.mem_data    = bus.in_data;
      bus.mem_address = (state_q == LOAD || state_q == DUMP) ? ptr_q : addr_q;
      bus.out_valid   = ovalid;
      bus.out_data    = (cnt_q == 2'd0 && inflight_q) ? bus.mem_q : b0_q;
      bus.busy        = state_q != IDLE;
      bus.done        = state_q == DONE;
   end
endmodule

// File: tb/tb_mem_stream_ctrl.sv
// tb_mem_stream_ctrl: directed checks of load, dump, wrap, stalls, len=0 and reset.
module tb_mem_stream_ctrl;
   logic clock = 1'b0;
   logic rst = 1'b0;
   always #5 clock = ~clock;
   mem_stream_ctrl_if #(.WIDTH(8), .ADDR_W(6)) bus();
   mem_stream_ctrl #(.WIDTH(8), .ADDR_W(6)) dut (.clock(clock), .rst(rst), .bus(bus));
   logic [7:0] ram [64];
   logic [7:0] shadow [64];
   logic [31:0] pat = 32'b1011_0110_1100_1011_0101_1001_1001_0011;
   int vectors = 0;
   int fails = 0;
   always @(posedge clock) begin
      if (bus.mem_wr_en) ram[bus.mem_address] <= bus.mem_data;
      bus.mem_q <= ram[bus.mem_address];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic do_load(input logic [5:0] b, input logic [6:0] n, input logic [7:0] d0);
      logic [5:0] a;
      @(negedge clock);
      bus.load_start = 1'b1; bus.base = b; bus.len = n; bus.in_valid = 1'b1; bus.in_data = d0;
      #1 chk("load_idle_in_ready", bus.in_ready, 0);
      for (int k = 0; k < int'(n); k++) begin
         @(negedge clock);
         bus.load_start = 1'b0;
         bus.dump_start = (k == 1);
         bus.in_data = d0 + 8'(k);
         a = b + 6'(k);
         #1;
         chk("load_wr_en", bus.mem_wr_en, 1);
         chk("load_addr", bus.mem_address, a);
         chk("load_data", bus.mem_data, d0 + 8'(k));
         chk("load_in_ready", bus.in_ready, 1);
         shadow[a] = d0 + 8'(k);
      end
      @(negedge clock);
      bus.dump_start = 1'b0;
      #1;
      chk("load_done", bus.done, 1);
      chk("load_done_in_ready", bus.in_ready, 0);
      chk("load_done_wr_en", bus.mem_wr_en, 0);
      @(negedge clock);
      bus.in_valid = 1'b0;
      #1;
      chk("load_idle_done", bus.done, 0);
      chk("load_idle_busy", bus.busy, 0);
   endtask
   task automatic do_dump(input logic [5:0] b, input logic [6:0] n, input int mode);
      logic [5:0] addrs [$];
      logic [5:0] a;
      logic [7:0] pd;
      int k, cyc, expc;
      bit fin, lp, pv, pr;
      @(negedge clock);
      bus.dump_start = 1'b1; bus.base = b; bus.len = n; bus.out_ready = 1'b1;
      #1 chk("dump_idle_valid", bus.out_valid, 0);
      k = 0; cyc = 0; fin = 0; lp = 0; pv = 0; pr = 1; pd = '0;
      while (!fin && cyc < 200) begin
         @(negedge clock);
         bus.dump_start = 1'b0;
         cyc++;
         bus.out_ready = (mode == 0) ? 1'b1 : pat[cyc % 32];
         #1;
         if (bus.done) begin
            chk("dump_done_after_last", 32'(lp), 1);
            chk("dump_done_valid", bus.out_valid, 0);
            fin = 1;
         end else begin
            chk("dump_wr_en", bus.mem_wr_en, 0);
            if (pv && !pr) begin
               chk("stall_valid", bus.out_valid, 1);
               chk("stall_data", bus.out_data, pd);
            end
            if (addrs.size() == 0 || addrs[addrs.size()-1] != bus.mem_address) addrs.push_back(bus.mem_address);
            lp = bus.out_valid && bus.out_ready;
            if (lp) begin
               a = b + 6'(k);
               chk("dump_word", bus.out_data, shadow[a]);
`ifdef MEM_STREAM_CTRL_SKID_EN
               expc = k + 2;
`else
               expc = 2 * k + 2;
`endif
               if (mode == 0) chk("dump_timing", cyc, expc);
               k++;
            end
            pv = bus.out_valid; pd = bus.out_data; pr = bus.out_ready;
         end
      end
      chk("dump_finished", 32'(fin), 1);
      chk("dump_count", k, 32'(n));
      for (int i = 0; i < int'(n) && i < addrs.size(); i++) begin
         a = b + 6'(i);
         chk("dump_addr", addrs[i], a);
      end
      @(negedge clock);
      bus.out_ready = 1'b0;
      #1;
      chk("dump_idle_done", bus.done, 0);
      chk("dump_idle_busy", bus.busy, 0);
   endtask
   initial begin
      int k, cyc;
      bus.load_start = 0; bus.dump_start = 0; bus.base = '0; bus.len = '0;
      bus.in_data = '0; bus.in_valid = 0; bus.out_ready = 0;
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_addr", bus.mem_address, 0);
      chk("rst_out_data", bus.out_data, 0);
      @(negedge clock);
      @(negedge clock);
      rst = 1'b0;
      do_load(6'd0, 7'd4, 8'hA0);
      do_dump(6'd0, 7'd4, 0);
      do_load(6'd60, 7'd12, 8'hB0);
      do_dump(6'd62, 7'd4, 0);
      do_dump(6'd0, 7'd8, 1);
      @(negedge clock);
      bus.load_start = 1; bus.dump_start = 1; bus.len = '0; bus.base = 6'd5; bus.in_valid = 1;
      #1 chk("len0_idle_wr_en", bus.mem_wr_en, 0);
      @(negedge clock);
      bus.load_start = 0; bus.dump_start = 0;
      #1;
      chk("len0_done", bus.done, 1);
      chk("len0_busy", bus.busy, 1);
      chk("len0_wr_en", bus.mem_wr_en, 0);
      chk("len0_in_ready", bus.in_ready, 0);
      @(negedge clock);
      #1;
      chk("len0_idle_done", bus.done, 0);
      chk("len0_idle_wr_en", bus.mem_wr_en, 0);
      @(negedge clock);
      bus.dump_start = 1; bus.base = '0; bus.len = 7'd8; bus.out_ready = 1;
      k = 0; cyc = 0;
      while (cyc < 50) begin
         @(negedge clock);
         bus.dump_start = 0;
         cyc++;
         #1;
         if (bus.out_valid && k == 2) break;
         if (bus.out_valid && bus.out_ready) k++;
      end
      chk("rst_mid_reached_third", k, 2);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", bus.out_valid, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_wr_en", bus.mem_wr_en, 0);
      chk("rst_mid_addr", bus.mem_address, 0);
      chk("rst_mid_out_data", bus.out_data, 0);
      @(negedge clock);
      #1 chk("rst_hold_wr_en", bus.mem_wr_en, 0);
      rst = 1'b0;
      bus.in_valid = 0;
      do_dump(6'd60, 7'd4, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
